// File: rtl/toysram_scan_pkg.sv
// Shared types and sizing for the toy SRAM scan responder.
package toysram_scan_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_SHIFT   = 2'd2,
      S_UPDATE  = 2'd3
   } scan_state_t;

   localparam int SCAN_LEN_DEF = 32;

   // Counter must reach SCAN_LEN+1 so that over-long sessions remain distinguishable.
   function automatic int cnt_width(input int len);
      return $clog2(len + 2);
   endfunction

endpackage

// File: rtl/toysram_scan_sync.sv
// Single-bit pad synchronizer, SYNC_STAGES flops deep, cleared by reset.
module toysram_scan_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic wb_clk_i,
   input  logic wb_rst_i,
   input  logic din,
   output logic dout
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) sync_q <= '0;
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], din};
   end

   assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/toysram_scan_ctl.sv
// GPIO scan responder: capture status, shift out/in, update config outputs.
// Optional build macro SCAN_LEN_CHECK_EN gates the config update on an exact shift count.
module toysram_scan_ctl
   import toysram_scan_pkg::*;
#(
   parameter int                  SCAN_LEN    = SCAN_LEN_DEF,
   parameter logic [SCAN_LEN-1:0] CFG_RST     = '0,
   parameter int                  SYNC_STAGES = 2
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                te_i,
   input  logic                scan_clk_i,
   input  logic                scan_in_i,
   output logic                scan_out_o,
   input  logic [SCAN_LEN-1:0] cap_data_i,
   output logic [SCAN_LEN-1:0] cfg_o,
   output logic                cfg_upd_o,
   output logic                busy_o,
   output logic                len_err_o
);

   localparam int                CNT_W   = cnt_width(SCAN_LEN);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SCAN_LEN + 1);

   logic te_s, sck_s, sin_s;
   logic te_q, sck_q;
   logic te_rise, sck_rise;

   scan_state_t         state, state_nxt;
   logic                do_capture, do_shift, do_update, load_ok;
   logic [SCAN_LEN-1:0] shreg;
   logic [CNT_W-1:0]    cnt;

   toysram_scan_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_te (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .din(te_i),       .dout(te_s));
   toysram_scan_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .din(scan_clk_i), .dout(sck_s));
   toysram_scan_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sin (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .din(scan_in_i),  .dout(sin_s));

   // Edge detect stage: previous-cycle copies of the synchronized pads
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         te_q  <= 1'b0;
         sck_q <= 1'b0;
      end else begin
         te_q  <= te_s;
         sck_q <= sck_s;
      end
   end

   assign te_rise  = te_s & ~te_q;
   assign sck_rise = sck_s & ~sck_q;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // SHIFT leaves on te_s low rather than only the fall pulse, so a fall that
   // lands during CAPTURE still ends the session; a coincident sck rise is dropped.
   always_comb begin
      state_nxt  = state;
      do_capture = 1'b0;
      do_shift   = 1'b0;
      do_update  = 1'b0;
      case (state)
         S_IDLE:    if (te_rise) state_nxt = S_CAPTURE;
         S_CAPTURE: begin
            do_capture = 1'b1;
            state_nxt  = S_SHIFT;
         end
         S_SHIFT: begin
            if (!te_s)         state_nxt = S_UPDATE;
            else if (sck_rise) do_shift  = 1'b1;
         end
         S_UPDATE: begin
            do_update = 1'b1;
            state_nxt = S_IDLE;
         end
      endcase
   end

`ifdef SCAN_LEN_CHECK_EN
   localparam logic [CNT_W-1:0] CNT_LEN = CNT_W'(SCAN_LEN);

   assign load_ok = (cnt == CNT_LEN);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)                   len_err_o <= 1'b0;
      else if (do_capture)            len_err_o <= 1'b0;
      else if (do_update && !load_ok) len_err_o <= 1'b1;
   end
`else
   assign load_ok   = 1'b1;
   assign len_err_o = 1'b0;
`endif

   // Shift/capture/update stage
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         shreg      <= '0;
         cnt        <= '0;
         scan_out_o <= 1'b0;
         cfg_o      <= CFG_RST;
         cfg_upd_o  <= 1'b0;
      end else begin
         if (do_capture) begin
            shreg <= cap_data_i;
            cnt   <= '0;
         end else if (do_shift) begin
            shreg <= {sin_s, shreg[SCAN_LEN-1:1]};
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
         end
         scan_out_o <= shreg[0];
         cfg_upd_o  <= do_update & load_ok;
         if (do_update && load_ok) cfg_o <= shreg;
      end
   end

   assign busy_o = (state != S_IDLE);

endmodule

// File: tb/tb_toysram_scan_ctl.sv
// Directed self-checking bench for toysram_scan_ctl (SCAN_LEN=32, SYNC_STAGES=2).
module tb_toysram_scan_ctl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        te = 1'b0, sck = 1'b0, sin = 1'b0;
   logic        scan_out;
   logic [31:0] cap = '0;
   logic [31:0] cfg;
   logic        cfg_upd, busy, len_err;

   int vectors = 0;
   int errors  = 0;
   int upd_seen = 0;
   logic [31:0] cfg_exp = 32'h0;

   toysram_scan_ctl #(.SCAN_LEN(32), .CFG_RST(32'h0), .SYNC_STAGES(2)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .te_i(te), .scan_clk_i(sck), .scan_in_i(sin),
      .scan_out_o(scan_out), .cap_data_i(cap), .cfg_o(cfg), .cfg_upd_o(cfg_upd),
      .busy_o(busy), .len_err_o(len_err));

   always #5 clk = ~clk;

   always @(negedge clk) if (cfg_upd === 1'b1) upd_seen++;

   task automatic pulse(input logic b);
      sin = b;
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic start_session(input logic [31:0] c);
      cap = c;
      te  = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic end_session();
      te = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      vectors++; if (scan_out !== 1'b0) begin errors++; $display("FAIL reset_scan_out got %b want 0", scan_out); end
      vectors++; if (cfg !== 32'h0) begin errors++; $display("FAIL reset_cfg got %h want 00000000", cfg); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      vectors++; if (cfg_upd !== 1'b0) begin errors++; $display("FAIL reset_cfg_upd got %b want 0", cfg_upd); end
      vectors++; if (len_err !== 1'b0) begin errors++; $display("FAIL reset_len_err got %b want 0", len_err); end
   endtask

   task automatic test_full_session();
      logic [31:0] d;
      logic [31:0] obs;
      int u0;
      d  = 32'h1234_5678;
      u0 = upd_seen;
      start_session(32'hA5A5_0F0F);
      vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy got %b want 1", busy); end
      vectors++; if (len_err !== 1'b0) begin errors++; $display("FAIL full_len_err_mid got %b want 0", len_err); end
      for (int i = 0; i < 32; i++) begin
         obs[i] = scan_out;
         pulse(d[i]);
      end
      vectors++; if (obs !== 32'hA5A5_0F0F) begin errors++; $display("FAIL full_scan_out got %h want a5a50f0f", obs); end
      end_session();
      cfg_exp = d;
      vectors++; if (cfg !== cfg_exp) begin errors++; $display("FAIL full_cfg got %h want %h", cfg, cfg_exp); end
      vectors++; if (upd_seen - u0 !== 1) begin errors++; $display("FAIL full_upd_pulses got %0d want 1", upd_seen - u0); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_after got %b want 0", busy); end
      vectors++; if (scan_out !== 1'b0) begin errors++; $display("FAIL full_scan_out_idle got %b want 0", scan_out); end
      vectors++; if (len_err !== 1'b0) begin errors++; $display("FAIL full_len_err got %b want 0", len_err); end
   endtask

   task automatic test_short_session();
      logic [31:0] c, d;
      int u0;
      c  = 32'hC3C3_1111;
      d  = 32'h0F0F_9999;
      u0 = upd_seen;
      start_session(c);
      for (int i = 0; i < 31; i++) pulse(d[i]);
      end_session();
`ifdef SCAN_LEN_CHECK_EN
      vectors++; if (cfg !== cfg_exp) begin errors++; $display("FAIL short_cfg got %h want %h", cfg, cfg_exp); end
      vectors++; if (len_err !== 1'b1) begin errors++; $display("FAIL short_len_err got %b want 1", len_err); end
      vectors++; if (upd_seen - u0 !== 0) begin errors++; $display("FAIL short_upd_pulses got %0d want 0", upd_seen - u0); end
`else
      cfg_exp = {d[30:0], c[31]};
      vectors++; if (cfg !== cfg_exp) begin errors++; $display("FAIL short_cfg got %h want %h", cfg, cfg_exp); end
      vectors++; if (upd_seen - u0 !== 1) begin errors++; $display("FAIL short_upd_pulses got %0d want 1", upd_seen - u0); end
`endif
   endtask

   task automatic test_coincident();
      logic [31:0] c, d;
      int u0;
      c  = 32'h0000_FFFF;
      d  = 32'h0000_0016;
      u0 = upd_seen;
      start_session(c);
      for (int i = 0; i < 5; i++) pulse(d[i]);
      sin = 1'b1;
      te  = 1'b0;
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
      repeat (6) @(negedge clk);
`ifdef SCAN_LEN_CHECK_EN
      vectors++; if (cfg !== cfg_exp) begin errors++; $display("FAIL coinc_cfg got %h want %h", cfg, cfg_exp); end
      vectors++; if (len_err !== 1'b1) begin errors++; $display("FAIL coinc_len_err got %b want 1", len_err); end
`else
      cfg_exp = {d[4:0], c[31:5]};
      vectors++; if (cfg !== cfg_exp) begin errors++; $display("FAIL coinc_cfg got %h want %h", cfg, cfg_exp); end
      vectors++; if (upd_seen - u0 !== 1) begin errors++; $display("FAIL coinc_upd_pulses got %0d want 1", upd_seen - u0); end
`endif
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL coinc_busy got %b want 0", busy); end
   endtask

   task automatic test_zero_shift();
      int u0;
      u0  = upd_seen;
      cap = 32'hDEAD_BEEF;
      te  = 1'b1;
      #1000;
      @(negedge clk);
      end_session();
`ifdef SCAN_LEN_CHECK_EN
      vectors++; if (cfg !== cfg_exp) begin errors++; $display("FAIL zero_cfg got %h want %h", cfg, cfg_exp); end
      vectors++; if (len_err !== 1'b1) begin errors++; $display("FAIL zero_len_err got %b want 1", len_err); end
      vectors++; if (upd_seen - u0 !== 0) begin errors++; $display("FAIL zero_upd_pulses got %0d want 0", upd_seen - u0); end
`else
      cfg_exp = 32'hDEAD_BEEF;
      vectors++; if (cfg !== cfg_exp) begin errors++; $display("FAIL zero_cfg got %h want %h", cfg, cfg_exp); end
      vectors++; if (upd_seen - u0 !== 1) begin errors++; $display("FAIL zero_upd_pulses got %0d want 1", upd_seen - u0); end
`endif
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      int u0;
      d  = 32'hFFFF_FFFF;
      u0 = upd_seen;
      start_session(32'h5555_AAAB);
      for (int i = 0; i < 10; i++) pulse(d[i]);
      vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b want 1", busy); end
      rst = 1'b1;
      te  = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      cfg_exp = 32'h0;
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
      vectors++; if (cfg !== cfg_exp) begin errors++; $display("FAIL rstmid_cfg got %h want %h", cfg, cfg_exp); end
      vectors++; if (scan_out !== 1'b0) begin errors++; $display("FAIL rstmid_scan_out got %b want 0", scan_out); end
      vectors++; if (upd_seen - u0 !== 0) begin errors++; $display("FAIL rstmid_upd_pulses got %0d want 0", upd_seen - u0); end
      vectors++; if (len_err !== 1'b0) begin errors++; $display("FAIL rstmid_len_err got %b want 0", len_err); end
   endtask

   initial begin
      test_reset();
      test_full_session();
      test_short_session();
      test_full_session();
      test_coincident();
      test_zero_shift();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
